iter_mul_unit: RTL and testbench



---
 rtl/mul_pkg.sv | 29 ++
 rtl/mul_sign_fix.sv | 18 +
 rtl/iter_mul_unit.sv | 184 ++++++++++++++++++
 tb/tb_iter_mul_unit.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared types and constants for the iterative RV32M multiplier.
// Build option: MUL_RADIX4_EN selects 2 multiplier bits per CALC cycle.
package mul_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned ACC_W = 2 * XLEN;

`ifdef MUL_RADIX4_EN
  localparam int unsigned MUL_RADIX_BITS = 2;
`else
  localparam int unsigned MUL_RADIX_BITS = 1;
`endif

  localparam int unsigned MUL_ITER = XLEN / MUL_RADIX_BITS;
  localparam int unsigned CNT_W    = $clog2(MUL_ITER);

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } mul_state_e;

endpackage

// File: rtl/mul_sign_fix.sv
// Conditional two's-complement negate; yields operand magnitudes and the
// sign-corrected final product.
module mul_sign_fix #(
  parameter int unsigned W = 64
) (
  input  logic [W-1:0] data_i,
  input  logic         neg_i,
  output logic [W-1:0] data_o
);

  always_comb begin
    data_o = data_i;
    if (neg_i) begin
      data_o = ~data_i + W'(1);
    end
  end

endmodule

// File: rtl/iter_mul_unit.sv
// Iterative RV32M MUL/MULH/MULHSU/MULHU unit: fixed-latency shift-add on operand
// magnitudes with a final sign fix. Build option: MUL_RADIX4_EN (radix-4 CALC).
module iter_mul_unit
  import mul_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            busy,
  output logic            stall,
  output logic            valid,
  output logic [XLEN-1:0] result
);

  mul_state_e state_q, state_d;

  logic             accept_c;
  logic             last_iter_c;
  logic             neg_a_c, neg_b_c;
  logic [XLEN-1:0]  a_mag_c, b_mag_c;
  logic [ACC_W-1:0] pp_c, fix_c;

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] mcand_q, mcand_d;
  logic [XLEN-1:0]  mplier_q, mplier_d;
  logic [XLEN-1:0]  result_q, result_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic             neg_a_q, neg_a_d;
  logic             neg_b_q, neg_b_d;
`ifdef MUL_RADIX4_EN
  logic [ACC_W-1:0] mcand3_q, mcand3_d;
`endif

  assign accept_c    = (state_q == IDLE) & start & ~funct3[2] & ~flush;
  assign last_iter_c = (cnt_q == CNT_W'(MUL_ITER - 1));

  // rs1 is signed for all but MULHU; rs2 only for MUL/MULH
  assign neg_a_c = (funct3[1:0] != F3_MULHU[1:0]) & op_a[XLEN-1];
  assign neg_b_c = ~funct3[1] & op_b[XLEN-1];

  mul_sign_fix #(.W(XLEN)) u_mag_a (
    .data_i (op_a),
    .neg_i  (neg_a_c),
    .data_o (a_mag_c)
  );

  mul_sign_fix #(.W(XLEN)) u_mag_b (
    .data_i (op_b),
    .neg_i  (neg_b_c),
    .data_o (b_mag_c)
  );

  mul_sign_fix #(.W(ACC_W)) u_fix_acc (
    .data_i (acc_q),
    .neg_i  (neg_a_q ^ neg_b_q),
    .data_o (fix_c)
  );

  // Partial product for the multiplier bits consumed this cycle
`ifdef MUL_RADIX4_EN
  always_comb begin
    pp_c = '0;
    case (mplier_q[1:0])
      2'd1:    pp_c = mcand_q;
      2'd2:    pp_c = mcand_q << 1;
      2'd3:    pp_c = mcand3_q;
      default: pp_c = '0;
    endcase
  end
`else
  assign pp_c = mplier_q[0] ? mcand_q : '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (accept_c) state_d = CALC;
        CALC:    if (last_iter_c) state_d = FIX;
        FIX:     state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    busy  = (state_q != IDLE);
    valid = (state_q == DONE);
    stall = (busy & ~valid) | ((state_q == IDLE) & start & ~funct3[2]);
  end

  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
`ifdef MUL_RADIX4_EN
    mcand3_d = mcand3_q;
`endif
    if (!flush) begin
      case (state_q)
        IDLE: begin
          if (accept_c) begin
            acc_d    = '0;
            cnt_d    = '0;
            mcand_d  = ACC_W'(a_mag_c);
            mplier_d = b_mag_c;
            op_d     = funct3[1:0];
            neg_a_d  = neg_a_c;
            neg_b_d  = neg_b_c;
`ifdef MUL_RADIX4_EN
            mcand3_d = ACC_W'(a_mag_c) + (ACC_W'(a_mag_c) << 1);
`endif
          end
        end
        CALC: begin
          acc_d    = acc_q + pp_c;
          mcand_d  = mcand_q << MUL_RADIX_BITS;
          mplier_d = mplier_q >> MUL_RADIX_BITS;
          cnt_d    = cnt_q + CNT_W'(1);
`ifdef MUL_RADIX4_EN
          mcand3_d = mcand3_q << MUL_RADIX_BITS;
`endif
        end
        FIX: begin
          acc_d    = fix_c;
          result_d = (op_q == F3_MUL[1:0]) ? fix_c[XLEN-1:0] : fix_c[ACC_W-1:XLEN];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      op_q     <= '0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
`ifdef MUL_RADIX4_EN
      mcand3_q <= '0;
`endif
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
`ifdef MUL_RADIX4_EN
      mcand3_q <= mcand3_d;
`endif
    end
  end

  assign result = result_q;

endmodule

// File: tb/tb_iter_mul_unit.sv
// Self-checking bench for iter_mul_unit: directed vector table, flush/reset/ignore
// sequences and random operations against a 64-bit arithmetic reference.
module tb_iter_mul_unit;

`ifdef MUL_RADIX4_EN
  localparam int LAT = 18;
`else
  localparam int LAT = 34;
`endif

  logic        clk;
  logic        rst;
  logic        start;
  logic        flush;
  logic [2:0]  funct3;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        busy;
  logic        stall;
  logic        valid;
  logic [31:0] result;

  int total;
  int bad;

  iter_mul_unit dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .flush  (flush),
    .funct3 (funct3),
    .op_a   (op_a),
    .op_b   (op_b),
    .busy   (busy),
    .stall  (stall),
    .valid  (valid),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
    end
  endtask

  // Reference: sign/zero-extend to 64 bits, multiply, pick the half
  function automatic logic [31:0] ref_mul(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] b);
    logic signed [63:0] sa, sb, p;
    sa = (f3 == 3'b011) ? $signed({32'd0, a}) : $signed({{32{a[31]}}, a});
    sb = (f3 == 3'b000 || f3 == 3'b001) ? $signed({{32{b[31]}}, b}) : $signed({32'd0, b});
    p  = sa * sb;
    return (f3 == 3'b000) ? p[31:0] : p[63:32];
  endfunction

  // Issue one op from an idle DUT, check handshake, latency and result
  task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input bit hold);
    int lat;
    bit stall_ok;
    funct3 = f3;
    op_a   = a;
    op_b   = b;
    start  = 1'b1;
    #1;
    chk({name, "_accept_stall"}, 64'(stall), 64'd1);
    @(posedge clk);
    #1;
    if (hold) begin
      funct3 = 3'b000;
      op_a   = $urandom;
      op_b   = $urandom;
    end else begin
      start = 1'b0;
    end
    lat      = 1;
    stall_ok = 1'b1;
    while (!valid && lat < 100) begin
      if (!(busy && stall)) stall_ok = 1'b0;
      @(posedge clk);
      #1;
      lat++;
    end
    start = 1'b0;
    chk({name, "_valid_seen"}, 64'(valid), 64'd1);
    chk({name, "_latency"}, 64'(lat), 64'(LAT));
    chk({name, "_stall_busy"}, 64'(stall_ok), 64'd1);
    chk({name, "_stall_at_valid"}, 64'(stall), 64'd0);
    chk({name, "_result"}, 64'(result), 64'(exp));
    @(posedge clk);
    #1;
    chk({name, "_valid_pulse"}, 64'(valid), 64'd0);
    chk({name, "_busy_drop"}, 64'(busy), 64'd0);
    chk({name, "_result_hold"}, 64'(result), 64'(exp));
  endtask

  task automatic watch_no_valid(input string name, input int cycles);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      if (valid || busy) seen = 1'b1;
    end
    chk(name, 64'(seen), 64'd0);
  endtask

  vec_t vecs[$];
  logic [31:0] pick[6];

  initial begin
    total  = 0;
    bad    = 0;
    rst    = 1'b1;
    start  = 1'b0;
    flush  = 1'b0;
    funct3 = 3'b000;
    op_a   = '0;
    op_b   = '0;

    vecs.push_back('{3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB});
    vecs.push_back('{3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000});
    vecs.push_back('{3'b011, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000});
    vecs.push_back('{3'b010, 32'h8000_0000, 32'h8000_0000, 32'hC000_0000});
    vecs.push_back('{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE});
    vecs.push_back('{3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001});
    vecs.push_back('{3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000});
    vecs.push_back('{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF});
    vecs.push_back('{3'b000, 32'h0000_0000, 32'h1234_5678, 32'h0000_0000});
    vecs.push_back('{3'b001, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF});

    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_stall", 64'(stall), 64'd0);
    chk("reset_valid", 64'(valid), 64'd0);
    chk("reset_result", 64'(result), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      run_op($sformatf("vec%0d", i), vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp, 1'b0);
    end

    // start held high while busy must not start a second op
    run_op("hold_start", 3'b000, 32'h0000_0009, 32'h0000_000B, 32'h0000_0063, 1'b1);

    // flush 10 cycles after accepting MUL 5x5
    funct3 = 3'b000;
    op_a   = 32'd5;
    op_b   = 32'd5;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush_busy", 64'(busy), 64'd0);
    chk("flush_valid", 64'(valid), 64'd0);
    watch_no_valid("flush_no_valid", 40);
    run_op("after_flush", 3'b000, 32'd2, 32'd3, 32'd6, 1'b0);

    // flush has priority over start in IDLE
    start = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    flush = 1'b0;
    chk("flush_prio_busy", 64'(busy), 64'd0);

    // reset at cycle 20 of an operation
    funct3 = 3'b001;
    op_a   = 32'h1234_5678;
    op_b   = 32'h9ABC_DEF0;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_stall", 64'(stall), 64'd0);
    chk("midrst_valid", 64'(valid), 64'd0);
    chk("midrst_result", 64'(result), 64'd0);
    watch_no_valid("midrst_no_valid", 40);

    // division encodings are never accepted
    funct3 = 3'b100;
    op_a   = 32'd10;
    op_b   = 32'd3;
    start  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("div_busy", 64'(busy), 64'd0);
      chk("div_stall", 64'(stall), 64'd0);
    end
    start = 1'b0;
    watch_no_valid("div_no_valid", 40);

    // random operations against the reference model
    for (int i = 0; i < 40; i++) begin
      logic [2:0]  f3;
      logic [31:0] a, b;
      pick[0] = 32'h0000_0000;
      pick[1] = 32'h0000_0001;
      pick[2] = 32'hFFFF_FFFF;
      pick[3] = 32'h8000_0000;
      pick[4] = 32'h7FFF_FFFF;
      pick[5] = $urandom;
      f3 = 3'($urandom_range(0, 3));
      a  = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 5)] : $urandom;
      b  = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 5)] : $urandom;
      run_op($sformatf("rnd%0d_f%0d_%h_%h", i, f3, a, b), f3, a, b, ref_mul(f3, a, b), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
